alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 2, ALU cycles for multiply (alu_control 4'b0110); legal range 1..15.
REQ-002 SHALL have parameter FP_LAT, default 3, ALU cycles for FP add (alu_control 4'b1001); legal range 1..15.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  2  bit i: requester i presents an operation.
REQ-006 SHALL have port req_ready  output  2  bit i: requester i's operation accepted this cycle.
REQ-007 SHALL have port req_ctrl  input  8  [4i+3:4i]: requester i's alu_control code.
REQ-008 SHALL have port req_a  input  64  [32i+31:32i]: requester i's operand 1.
REQ-009 SHALL have port req_b  input  64  [32i+31:32i]: requester i's operand 2.
REQ-010 SHALL have port alu_in1  output  32  operand 1 to the shared ALU.
REQ-011 SHALL have port alu_in2  output  32  operand 2 to the shared ALU.
REQ-012 SHALL have port alu_control  output  4  operation code to the shared ALU.
REQ-013 SHALL have port alu_result  input  32  ALU result.
REQ-014 SHALL have port alu_zero  input  1  ALU zero flag.
REQ-015 SHALL have port rsp_valid  output  2  bit i: response for requester i is pending.
REQ-016 SHALL have port rsp_ready  input  2  bit i: requester i takes its response.
REQ-017 SHALL have port rsp_data  output  32  captured result; shared by both requesters.
REQ-018 SHALL have port rsp_zero  output  1  captured zero flag.
REQ-019 SHALL have port rsp_err  output  1  high when the issued code is unsupported.
REQ-020 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-021 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; at most one operation is in flight.
REQ-022 In IDLE, SHALL grant one valid requester combinationally; the granted req_ready bit is high that cycle; if both request, the grant goes to the requester not served last (round-robin on last_grant).
REQ-023 SHALL assert req_ready only in IDLE, with at most one bit set; a req_valid that drops before the grant is never accepted.
REQ-024 On accept, SHALL latch ctrl/a/b and owner; load cnt = LAT-1, where LAT = MUL_LAT for 0110, FP_LAT for 1001, else 1; then enter EXEC.
REQ-025 SHALL drive alu_in1/alu_in2/alu_control from the latched registers at all times, so they are stable throughout EXEC.
REQ-026 In EXEC, SHALL decrement cnt each cycle; when cnt==0, capture alu_result to rsp_data and alu_zero to rsp_zero, then enter RESP.
REQ-027 Supported codes SHALL be 0000, 0001, 0010, 0011, 0100, 0101, 0110, 0111, 1000 and 1001; for any other code, rsp_err=1, rsp_data=0, rsp_zero=1, with LAT=1.
REQ-028 Timing: accept at cycle T, EXEC T+1..T+LAT, rsp_valid[owner] high from T+LAT+1.
REQ-029 In RESP, SHALL hold rsp_valid[owner], rsp_data, rsp_zero and rsp_err stable until rsp_ready[owner]=1, then go to IDLE and set last_grant=owner; rsp_ready of the non-owner is ignored.
REQ-030 If rsp_ready is already high on the first RESP cycle, RESP SHALL last exactly one cycle; the next accept is possible one cycle later, in IDLE.
REQ-031 cnt SHALL be 4 bits wide, with no wrap: it is only decremented when non-zero.

Reset
REQ-032 When reset_n=0 at a clock edge, SHALL go to IDLE and clear: cnt=0, owner=0, latched ctrl/a/b=0 (so alu_* outputs = 0), rsp_data=0, rsp_zero=0, rsp_err=0, rsp_valid=0, req_ready=0, busy=0, last_grant=1 (requester 0 wins the first tie).
REQ-033 Reset in EXEC or RESP SHALL drop the in-flight operation; no response is ever produced for it.

Verification
REQ-034 Single op: req_valid=01, ctrl=0010, a=5, b=7 -> req_ready=01 at T; rsp_valid=01 at T+2; rsp_data=12, rsp_zero=0.
REQ-035 Tie: both valid after reset, ctrl0=0100 (a=b=9), ctrl1=0001 -> requester 0 is served first with rsp_zero=1; requester 1 is accepted in the first IDLE cycle after requester 0's response handshake.
REQ-036 Latency: ctrl=0110 with MUL_LAT=2, a=3, b=4 -> rsp_valid at T+3, rsp_data=12; ctrl=1001 with FP_LAT=3 -> rsp_valid at T+4; alu_* outputs stable across EXEC.
REQ-037 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data and busy held; req_ready stays 00 despite req_valid=11.
REQ-038 Illegal code 1111 -> rsp_err=1, rsp_data=0, rsp_zero=1 at T+2.
REQ-039 Reset mid-EXEC (ctrl=1001) -> next cycle busy=0, rsp_valid=00; no response is later produced for that operation.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: arbitrates two requesters onto one shared multi-cycle ALU.
// One operation is in flight at a time (IDLE -> EXEC -> RESP -> IDLE).
//
// Parameters
//   MUL_LAT   ALU cycles for multiply (code 4'b0110), 1..15
//   FP_LAT    ALU cycles for FP add (code 4'b1001), 1..15
// Ports
//   clock, reset_n             clock and synchronous active-low reset
//   req_valid/req_ready        per-requester request handshake (bit i = requester i)
//   req_ctrl/req_a/req_b       packed per-requester code and operands
//   alu_in1/alu_in2/alu_control  latched operation driven to the shared ALU
//   alu_result/alu_zero        ALU outputs, captured at the end of EXEC
//   rsp_valid/rsp_ready        per-requester response handshake
//   rsp_data/rsp_zero/rsp_err  captured response, shared by both requesters
//   busy                       high whenever the FSM is not idle
module alu_issue_ctrl #(
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned FP_LAT  = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [7:0]  req_ctrl,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [3:0]  alu_control,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_zero,
    output logic        rsp_err,
    output logic        busy
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StExec = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    localparam logic [3:0] MulCnt = 4'(MUL_LAT - 1);
    localparam logic [3:0] FpCnt  = 4'(FP_LAT - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] data_q, data_d;
    logic        zero_q, zero_d;
    logic        err_q, err_d;

    logic [1:0]  grant;
    logic        gnt_idx;
    logic [3:0]  sel_ctrl;

    // Round-robin: on a tie the requester not served last wins.
    always_comb begin
        grant = 2'b00;
        if (state_q == StIdle) begin
            if (req_valid == 2'b11) begin
                grant = last_q ? 2'b01 : 2'b10;
            end else begin
                grant = req_valid;
            end
        end
    end

    assign gnt_idx  = grant[1];
    assign sel_ctrl = gnt_idx ? req_ctrl[7:4] : req_ctrl[3:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        ctrl_d  = ctrl_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        zero_d  = zero_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (grant != 2'b00) begin
                    owner_d = gnt_idx;
                    ctrl_d  = sel_ctrl;
                    a_d     = gnt_idx ? req_a[63:32] : req_a[31:0];
                    b_d     = gnt_idx ? req_b[63:32] : req_b[31:0];
                    if (sel_ctrl == 4'b0110) begin
                        cnt_d = MulCnt;
                    end else if (sel_ctrl == 4'b1001) begin
                        cnt_d = FpCnt;
                    end else begin
                        cnt_d = 4'd0;
                    end
                    state_d = StExec;
                end
            end
            StExec: begin
                if (cnt_q == 4'd0) begin
                    // Codes above 1001 are unsupported: fixed error response.
                    if (ctrl_q > 4'b1001) begin
                        data_d = 32'd0;
                        zero_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        data_d = alu_result;
                        zero_d = alu_zero;
                        err_d  = 1'b0;
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready[owner_q]) begin
                    last_d  = owner_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            ctrl_q  <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            data_q  <= 32'd0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            ctrl_q  <= ctrl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign req_ready   = grant;
    assign alu_in1     = a_q;
    assign alu_in2     = b_q;
    assign alu_control = ctrl_q;
    assign rsp_valid   = (state_q == StResp) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data    = data_q;
    assign rsp_zero    = zero_q;
    assign rsp_err     = err_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a transaction model.
module tb_alu_issue_ctrl;

    localparam int unsigned MulLat = 2;
    localparam int unsigned FpLat  = 3;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_ctrl;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_zero;
    logic        rsp_err;
    logic        busy;

    int n_checks = 0;
    int n_err    = 0;

    alu_issue_ctrl #(
        .MUL_LAT (MulLat),
        .FP_LAT  (FpLat)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_ctrl    (req_ctrl),
        .req_a       (req_a),
        .req_b       (req_b),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_zero    (rsp_zero),
        .rsp_err     (rsp_err),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    // Stand-in shared ALU; unsupported codes return garbage the DUT must mask.
    function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] x,
                                           input logic [31:0] y);
        case (c)
            4'd0:    return x & y;
            4'd1:    return x | y;
            4'd2:    return x + y;
            4'd3:    return x ^ y;
            4'd4:    return x - y;
            4'd5:    return {31'd0, $signed(x) < $signed(y)};
            4'd6:    return x * y;
            4'd7:    return ~(x | y);
            4'd8:    return x << y[4:0];
            4'd9:    return x + y + 32'd1;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb begin
        alu_result = alu_fn(alu_control, alu_in1, alu_in2);
        alu_zero   = (alu_result == 32'd0);
    end

    function automatic int lat_of(input logic [3:0] c);
        if (c == 4'b0110) return MulLat;
        if (c == 4'b1001) return FpLat;
        return 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n   = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_ctrl  = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  valid;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  exp_grant;
        int          exp_lat;
        logic [31:0] exp_data;
        logic        exp_zero;
        logic        exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic apply_vec(input vec_t v);
        int   n;
        logic stable;
        do_reset();
        @(negedge clock);
        req_valid = v.valid;
        // Unused slot carries distracting values to catch wrong-slot muxing.
        if (v.valid[1]) begin
            req_ctrl = {v.ctrl, 4'h6};
            req_a    = {v.a, 32'hFFFF_FFFF};
            req_b    = {v.b, 32'h1234_5678};
        end else begin
            req_ctrl = {4'h6, v.ctrl};
            req_a    = {32'hFFFF_FFFF, v.a};
            req_b    = {32'h1234_5678, v.b};
        end
        #1;
        chk("vec_grant", {30'd0, req_ready}, {30'd0, v.exp_grant});
        @(negedge clock);
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        #1;
        chk("vec_busy_exec", {31'd0, busy}, 32'd1);
        stable = 1'b1;
        n = 1;
        while (rsp_valid == 2'b00 && n < 20) begin
            if (alu_in1 !== v.a || alu_in2 !== v.b || alu_control !== v.ctrl) stable = 1'b0;
            @(negedge clock);
            #1;
            n++;
        end
        chk("vec_alu_stable", {31'd0, stable}, 32'd1);
        chk("vec_latency", n, v.exp_lat + 1);
        chk("vec_rsp_valid", {30'd0, rsp_valid}, {30'd0, v.exp_grant});
        chk("vec_rsp_data", rsp_data, v.exp_data);
        chk("vec_rsp_zero", {31'd0, rsp_zero}, {31'd0, v.exp_zero});
        chk("vec_rsp_err", {31'd0, rsp_err}, {31'd0, v.exp_err});
        rsp_ready = 2'b11;
        @(negedge clock);
        rsp_ready = 2'b00;
        #1;
        chk("vec_idle_after", {30'd0, busy, rsp_valid != 2'b00}, 32'd0);
    endtask

    // Transaction-level reference model for the random phase.
    logic        m_busy;
    logic        m_owner;
    logic        m_last;
    int          m_resp_at;
    logic [3:0]  m_ctrl;
    logic [31:0] m_a, m_b;
    logic [1:0]  e_ready, e_rv;
    int          cyc;
    logic        quiet;

    initial begin
        reset_n   = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_ctrl  = '0;
        req_a     = '0;
        req_b     = '0;

        vecs[0] = '{2'b01, 4'b0010, 32'd5,    32'd7,    2'b01, 1,     32'd12,         1'b0, 1'b0};
        vecs[1] = '{2'b01, 4'b0110, 32'd3,    32'd4,    2'b01, 2,     32'd12,         1'b0, 1'b0};
        vecs[2] = '{2'b10, 4'b1001, 32'd1,    32'd2,    2'b10, 3,     32'd4,          1'b0, 1'b0};
        vecs[3] = '{2'b01, 4'b1111, 32'd3,    32'd3,    2'b01, 1,     32'd0,          1'b1, 1'b1};
        vecs[4] = '{2'b10, 4'b0000, 32'hF0,   32'h3C,   2'b10, 1,     32'h30,         1'b0, 1'b0};
        vecs[5] = '{2'b01, 4'b0100, 32'd9,    32'd9,    2'b01, 1,     32'd0,          1'b1, 1'b0};
        vecs[6] = '{2'b10, 4'b1100, 32'd1,    32'd1,    2'b10, 1,     32'd0,          1'b1, 1'b1};
        vecs[7] = '{2'b10, 4'b0111, 32'd0,    32'd0,    2'b10, 1,     32'hFFFF_FFFF,  1'b0, 1'b0};
        vecs[8] = '{2'b01, 4'b1000, 32'd1,    32'd4,    2'b01, 1,     32'h10,         1'b0, 1'b0};

        for (int i = 0; i < 9; i++) apply_vec(vecs[i]);

        // Reset clears everything, including state left by the last vector.
        do_reset();
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_alu_in1", alu_in1, 32'd0);
        chk("rst_alu_in2", alu_in2, 32'd0);
        chk("rst_alu_control", {28'd0, alu_control}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_flags", {30'd0, rsp_zero, rsp_err}, 32'd0);

        // Tie after reset: requester 0 first, requester 1 in the first idle cycle.
        do_reset();
        @(negedge clock);
        req_valid = 2'b11;
        req_ctrl  = {4'b0001, 4'b0100};
        req_a     = {32'd3, 32'd9};
        req_b     = {32'd4, 32'd9};
        #1;
        chk("tie_grant0", {30'd0, req_ready}, 32'h1);
        @(negedge clock);
        req_valid = 2'b10;
        #1;
        chk("tie_exec_ready", {30'd0, req_ready}, 32'h0);
        @(negedge clock);
        #1;
        chk("tie_rsp0_valid", {30'd0, rsp_valid}, 32'h1);
        chk("tie_rsp0_zero", {31'd0, rsp_zero}, 32'd1);
        chk("tie_rsp0_data", rsp_data, 32'd0);
        rsp_ready = 2'b01;
        @(negedge clock);
        rsp_ready = 2'b00;
        #1;
        chk("tie_grant1", {30'd0, req_ready}, 32'h2);
        @(negedge clock);
        req_valid = 2'b00;
        @(negedge clock);
        #1;
        chk("tie_rsp1_valid", {30'd0, rsp_valid}, 32'h2);
        chk("tie_rsp1_data", rsp_data, 32'd7);
        rsp_ready = 2'b10;
        @(negedge clock);
        rsp_ready = 2'b00;
        req_valid = 2'b11;
        #1;
        chk("tie_rr_back_to_0", {30'd0, req_ready}, 32'h1);

        // Backpressure: response held, new requests refused, non-owner ready ignored.
        do_reset();
        @(negedge clock);
        req_valid = 2'b01;
        req_ctrl  = {4'b0010, 4'b0010};
        req_a     = {32'd1, 32'd20};
        req_b     = {32'd1, 32'd22};
        #1;
        chk("bp_grant", {30'd0, req_ready}, 32'h1);
        @(negedge clock);
        req_valid = 2'b11;
        @(negedge clock);
        #1;
        chk("bp_rsp_valid", {30'd0, rsp_valid}, 32'h1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            rsp_ready = 2'b10;
            #1;
            chk("bp_hold_valid", {30'd0, rsp_valid}, 32'h1);
            chk("bp_hold_data", rsp_data, 32'd42);
            chk("bp_hold_busy", {31'd0, busy}, 32'd1);
            chk("bp_hold_ready", {30'd0, req_ready}, 32'h0);
        end
        @(negedge clock);
        rsp_ready = 2'b01;
        @(negedge clock);
        rsp_ready = 2'b00;
        #1;
        chk("bp_next_grant", {30'd0, req_ready}, 32'h2);

        // Reset mid-EXEC drops the operation for good.
        do_reset();
        @(negedge clock);
        req_valid = 2'b01;
        req_ctrl  = {4'b0000, 4'b1001};
        req_a     = 64'd1;
        req_b     = 64'd1;
        #1;
        chk("rx_grant", {30'd0, req_ready}, 32'h1);
        @(negedge clock);
        req_valid = 2'b00;
        #1;
        chk("rx_busy_exec", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        @(negedge clock);
        #1;
        chk("rx_busy_cleared", {31'd0, busy}, 32'd0);
        chk("rx_rsp_cleared", {30'd0, rsp_valid}, 32'h0);
        reset_n   = 1'b1;
        rsp_ready = 2'b11;
        quiet     = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            #1;
            if (rsp_valid != 2'b00 || busy) quiet = 1'b0;
        end
        chk("rx_no_late_rsp", {31'd0, quiet}, 32'd1);

        // Randomized traffic against the transaction model.
        do_reset();
        m_busy = 1'b0;
        m_owner = 1'b0;
        m_last = 1'b1;
        m_resp_at = 0;
        m_ctrl = '0;
        m_a = '0;
        m_b = '0;
        cyc = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            req_valid = 2'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++) begin
                req_ctrl[4*i +: 4]  = 4'($urandom_range(0, 15));
                req_a[32*i +: 32]   = ($urandom_range(0, 3) == 0) ? $urandom
                                                                   : $urandom_range(0, 20);
                req_b[32*i +: 32]   = ($urandom_range(0, 3) == 0) ? $urandom
                                                                   : $urandom_range(0, 20);
            end
            rsp_ready = 2'($urandom_range(0, 3));
            #1;
            if (m_busy) e_ready = 2'b00;
            else if (req_valid == 2'b11) e_ready = m_last ? 2'b01 : 2'b10;
            else e_ready = req_valid;
            e_rv = (m_busy && cyc >= m_resp_at) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
            chk("rnd_req_ready", {30'd0, req_ready}, {30'd0, e_ready});
            chk("rnd_busy", {31'd0, busy}, {31'd0, m_busy});
            chk("rnd_rsp_valid", {30'd0, rsp_valid}, {30'd0, e_rv});
            if (m_busy) begin
                chk("rnd_alu_in1", alu_in1, m_a);
                chk("rnd_alu_in2", alu_in2, m_b);
                chk("rnd_alu_ctrl", {28'd0, alu_control}, {28'd0, m_ctrl});
            end
            if (e_rv != 2'b00) begin
                if (m_ctrl > 4'd9) begin
                    chk("rnd_rsp_data", rsp_data, 32'd0);
                    chk("rnd_rsp_flags", {30'd0, rsp_zero, rsp_err}, 32'h3);
                end else begin
                    chk("rnd_rsp_data", rsp_data, alu_fn(m_ctrl, m_a, m_b));
                    chk("rnd_rsp_flags", {30'd0, rsp_zero, rsp_err},
                        {30'd0, alu_fn(m_ctrl, m_a, m_b) == 32'd0, 1'b0});
                end
                if (rsp_ready[m_owner]) begin
                    m_busy = 1'b0;
                    m_last = m_owner;
                end
            end else if (e_ready != 2'b00) begin
                m_busy    = 1'b1;
                m_owner   = e_ready[1];
                m_ctrl    = req_ctrl[4*e_ready[1] +: 4];
                m_a       = req_a[32*e_ready[1] +: 32];
                m_b       = req_b[32*e_ready[1] +: 32];
                m_resp_at = cyc + lat_of(m_ctrl) + 1;
            end
            cyc++;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
